mem_arbiter: RTL and testbench

Two-master round-robin arbiter that shares the single-port picorv32-style memory block between two requesters, for example the CPU and a DMA engine or a second core.
- Each master and the memory use the native valid/ready/instr/wstrb/wdata/addr/rdata handshake.
- Sits directly in front of the memory controller.
- Latches the winning request and holds it stable until memory completes.
- A watchdog completes hung transactions with an error pulse.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port picorv32-style memory.
// Latches the winning request, holds it until completion, and times out hung accesses.
module mem_arbiter #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_addr,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_addr,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  output logic [31:0] s_addr,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s_valid_q, s_valid_d;
  logic               s_instr_q, s_instr_d;
  logic [3:0]         s_wstrb_q, s_wstrb_d;
  logic [31:0]        s_wdata_q, s_wdata_d;
  logic [31:0]        s_addr_q, s_addr_d;
  logic               m0_ready_q, m0_ready_d;
  logic               m1_ready_q, m1_ready_d;
  logic [31:0]        m0_rdata_q, m0_rdata_d;
  logic [31:0]        m1_rdata_q, m1_rdata_d;
  logic               timeout_err_q, timeout_err_d;

  logic win;        // arbitration winner in IDLE
  logic gnt;        // master currently granted
  logic gnt_valid;  // granted master still requesting

  // On contention the master that was not served last wins.
  assign win       = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
  assign gnt       = (state_q == GRANT1);
  assign gnt_valid = gnt ? m1_valid : m0_valid;

  always_comb begin
    // NOTE: every variable gets a default here, otherwise an unassigned path infers a latch.
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    s_valid_d     = s_valid_q;
    s_instr_d     = s_instr_q;
    s_wstrb_d     = s_wstrb_q;
    s_wdata_d     = s_wdata_q;
    s_addr_d      = s_addr_q;
    m0_ready_d    = 1'b0;
    m1_ready_d    = 1'b0;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          s_valid_d    = 1'b1;
          s_instr_d    = win ? m1_instr : m0_instr;
          s_wstrb_d    = win ? m1_wstrb : m0_wstrb;
          s_wdata_d    = win ? m1_wdata : m0_wdata;
          s_addr_d     = win ? m1_addr  : m0_addr;
          last_grant_d = win;
          cnt_d        = '0;
          state_d      = win ? GRANT1 : GRANT0;
        end
      end
      GRANT0, GRANT1: begin
        if (s_ready || cnt_q == CNT_MAX) begin
          if (gnt) begin
            m1_rdata_d = s_ready ? s_rdata : ERR_RDATA;
            m1_ready_d = 1'b1;
          end else begin
            m0_rdata_d = s_ready ? s_rdata : ERR_RDATA;
            m0_ready_d = 1'b1;
          end
          timeout_err_d = !s_ready;
          s_valid_d     = 1'b0;
          state_d       = DRAIN;
        end else if (!gnt_valid) begin
          // Master abandoned its request: release memory without completing.
          s_valid_d = 1'b0;
          state_d   = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (!s_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      s_valid_q     <= 1'b0;
      s_instr_q     <= 1'b0;
      s_wstrb_q     <= '0;
      s_wdata_q     <= '0;
      s_addr_q      <= '0;
      m0_ready_q    <= 1'b0;
      m1_ready_q    <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      s_valid_q     <= s_valid_d;
      s_instr_q     <= s_instr_d;
      s_wstrb_q     <= s_wstrb_d;
      s_wdata_q     <= s_wdata_d;
      s_addr_q      <= s_addr_d;
      m0_ready_q    <= m0_ready_d;
      m1_ready_q    <= m1_ready_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign s_valid     = s_valid_q;
  assign s_instr     = s_instr_q;
  assign s_wstrb     = s_wstrb_q;
  assign s_wdata     = s_wdata_q;
  assign s_addr      = s_addr_q;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: single reads/writes, contention,
// alternation, drain hold-off, watchdog timeout and asynchronous reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resn;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic [31:0] m0_wdata, m0_addr, m1_wdata, m1_addr;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready, timeout_err;
  logic [31:0] s_wdata, s_addr, s_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hBADBAD00)) dut (
    .clk(clk), .resn(resn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata),
    .m0_addr(m0_addr), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
    .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_addr(s_addr), .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resn = 1'b0;
    m0_valid = 0; m0_instr = 0; m0_wstrb = 0; m0_wdata = 0; m0_addr = 0;
    m1_valid = 0; m1_instr = 0; m1_wstrb = 0; m1_wdata = 0; m1_addr = 0;
    s_ready = 0; s_rdata = 0;
    #12;
    check("rst_s_valid", s_valid, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_wstrb", s_wstrb, 0);
    check("rst_m0_ready", m0_ready, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_timeout", timeout_err, 0);
    resn = 1'b1;

    // Single m0 read, memory ready two cycles after s_valid
    m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    step();
    check("t1_s_valid", s_valid, 1);
    check("t1_s_addr", s_addr, 32'h100);
    check("t1_s_wstrb", s_wstrb, 0);
    step();
    check("t1_no_early_ready", m0_ready, 0);
    s_ready = 1; s_rdata = 32'hDEADBEEF;
    step();
    check("t1_m0_ready", m0_ready, 1);
    check("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_m1_ready", m1_ready, 0);
    check("t1_s_valid_low", s_valid, 0);
    m0_valid = 0; s_ready = 0; s_rdata = 32'h0;
    step();
    check("t1_ready_pulse", m0_ready, 0);
    check("t1_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // Simultaneous requests after reset: m0 write first, then m1 read
    resn = 0; #3; resn = 1;
    m0_valid = 1; m0_addr = 32'h10; m0_wdata = 32'h11223344; m0_wstrb = 4'hF;
    m1_valid = 1; m1_addr = 32'h20; m1_wdata = 32'h0;        m1_wstrb = 4'h0;
    step();
    check("t2_first_addr", s_addr, 32'h10);
    check("t2_wdata", s_wdata, 32'h11223344);
    check("t2_wstrb", s_wstrb, 4'hF);
    s_ready = 1;
    step();
    check("t2_m0_ready", m0_ready, 1);
    check("t2_m1_wait", m1_ready, 0);
    m0_valid = 0; s_ready = 0;
    step();
    step();
    check("t2_second_addr", s_addr, 32'h20);
    check("t2_second_wstrb", s_wstrb, 0);
    s_ready = 1; s_rdata = 32'hCAFE0001;
    step();
    check("t2_m1_ready", m1_ready, 1);
    check("t2_m1_rdata", m1_rdata, 32'hCAFE0001);
    check("t2_m0_quiet", m0_ready, 0);
    m1_valid = 0; s_ready = 0;
    step();

    // Continuous contention: grants alternate starting with m0
    m0_valid = 1; m0_addr = 32'hA0; m0_wstrb = 0;
    m1_valid = 1; m1_addr = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("t3_addr_%0d", i), s_addr, (i % 2 == 0) ? 32'hA0 : 32'hB0);
      s_ready = 1; s_rdata = 32'h1000 + i;
      step();
      check($sformatf("t3_m0_ready_%0d", i), m0_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("t3_m1_ready_%0d", i), m1_ready, (i % 2 == 0) ? 0 : 1);
      s_ready = 0;
      step();
      check($sformatf("t3_pulse_%0d", i), {m0_ready, m1_ready}, 0);
    end
    check("t3_m0_rdata", m0_rdata, 32'h1004);
    check("t3_m1_rdata", m1_rdata, 32'h1005);
    m0_valid = 0; m1_valid = 0;

    // Memory keeps s_ready high after completion: stay drained
    m0_valid = 1; m0_addr = 32'hC0;
    step();
    check("t4_s_valid", s_valid, 1);
    s_ready = 1; s_rdata = 32'h55AA55AA;
    step();
    check("t4_m0_ready", m0_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4_no_ready_%0d", i), m0_ready, 0);
      check($sformatf("t4_no_reissue_%0d", i), s_valid, 0);
    end
    m0_valid = 0; s_ready = 0;
    step();
    check("t4_exit", s_valid, 0);
    check("t4_rdata", m0_rdata, 32'h55AA55AA);

    // Watchdog: memory never readies m1
    m1_valid = 1; m1_addr = 32'h300;
    step();
    check("t5_s_valid", s_valid, 1);
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("t5_wait_%0d", i), {s_valid, m1_ready, timeout_err}, 3'b100);
    end
    step();
    check("t5_m1_ready", m1_ready, 1);
    check("t5_m1_rdata", m1_rdata, 32'hBADBAD00);
    check("t5_timeout", timeout_err, 1);
    check("t5_s_valid_low", s_valid, 0);
    m1_valid = 0;
    step();
    check("t5_pulse", {m1_ready, timeout_err}, 0);
    m0_valid = 1; m0_addr = 32'hD0;
    step();
    check("t5_back_idle", s_addr, 32'hD0);
    s_ready = 1;
    step();
    m0_valid = 0; s_ready = 0;
    step();

    // Asynchronous reset during GRANT1
    m1_valid = 1; m1_addr = 32'h400;
    step();
    check("t6_grant1", s_addr, 32'h400);
    #3;
    resn = 0;
    #1;
    check("t6_async_drop", s_valid, 0);
    m0_valid = 1; m0_addr = 32'hE0; s_ready = 1;
    step();
    check("t6_no_m1_ready", m1_ready, 0);
    s_ready = 0;
    #3; resn = 1;
    step();
    check("t6_m0_first", s_addr, 32'hE0);
    check("t6_s_valid", s_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
